bcd_display_counter: RTL and testbench
======================================

Name: bcd_display_counter

Overview:
- Parametrised N-digit BCD up/down counter with built-in tick prescaler and per-digit 7-segment drive.
- Successor to the single-digit mod-10 counter plus separate divided clock. The counter stays in the `clk` domain and advances on an internal enable tick instead of a derived clock.
- Feeds the board's multi-digit 7-segment bank (stopwatch/counter display) and exposes a terminal-count pulse for cascading.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- TICK_FREQ, 1, count-step rate in Hz. DIV = CLK_FREQ/TICK_FREQ, integer, must be >= 1.
- DIGITS, 4, number of BCD digits, 1..8.
- MAX_COUNT, 9999, wrap value in decimal. Must be < 10**DIGITS.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = prescaler runs; 0 = prescaler and count hold.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load request.
- load_value  in  4*DIGITS  BCD value to load; digit 0 = bits [3:0].
- count  out  4*DIGITS  current BCD count, registered.
- segs  out  7*DIGITS  active-low segments per digit. Digit k = bits [7k+6:7k], bit order {a,b,c,d,e,f,g}.
- tick  out  1  one-cycle pulse in the cycle after each count step.
- tc  out  1  one-cycle pulse in the cycle after a wrap (up 99..→0 or down 0→MAX).

Behaviour:
- Reset (reset=0, async):
  - Prescaler pcnt=0, count=0, tick=0, tc=0.
  - segs shows "0" on digit 0. Other digits show "0", or are blank (7'h7F) if BLANK_LZ=1.
- Prescaler:
  - pcnt counts 0..DIV-1 while enable=1 and holds its value while enable=0.
  - A step occurs at an edge where enable=1 and pcnt==DIV-1; pcnt returns to 0 at that edge.
  - DIV=1 means a step on every enabled edge.
- Step, up=1:
  - count==MAX_COUNT: count<=0, tc<=1.
  - Otherwise count<=count+1 with decimal carry digit-to-digit (9→0 carries).
- Step, up=0:
  - count==0: count<=MAX_COUNT, tc<=1.
  - Otherwise count<=count-1 with decimal borrow (0→9 borrows).
- tick<=1 on every step edge, otherwise 0. tc<=0 on every non-wrap edge. Both are registered, single-cycle pulses.
- Load has priority over a step at the same edge:
  - count<=load_value, pcnt<=0, tick<=0, tc<=0.
  - If any load_value digit >9 or the value > MAX_COUNT, count<=0 instead.
  - load works regardless of enable.
- Direction changes take effect at the next step. No extra latency, no pcnt reset.
- segs is combinational from count (0-cycle latency).
  - Codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Blank = 1111111.
  - BLANK_LZ=1: digit k>0 is blanked iff it and all higher digits are 0.
- Reset asserted mid-count: immediate return to reset values. No pending tick or tc survives.
- pcnt width = $clog2(DIV)+1. Comparisons are on whole BCD vectors (MAX_COUNT converted to BCD at elaboration).

Decomposition:
- Shared package seg7_pkg:
  - typedef bcd_t (logic [3:0]), typedef seg7_t (logic [6:0]).
  - SEG7_BLANK constant.
  - Constant function to_bcd(int, digits) for the MAX_COUNT conversion.
  - seg7_encode(bcd_t) function holding the code table.
- Sub-module bcd_digit: one decimal digit with inputs step, up, carry_in/borrow_in and outputs digit, carry_out/borrow_out. Instantiated DIGITS times in a generate loop.
- Top-level owns the prescaler, load/wrap logic and segment encoding.

Test Plan (CLK_FREQ=8, TICK_FREQ=2 → DIV=4; DIGITS=2; MAX_COUNT=59 unless noted):
- Reset released, enable=1, up=1 for 16 clks -> tick pulses at clks 4, 8, 12, 16; count 0x04; segs digit0=1001100, digit1=0000001.
- load 0x58, up=1, run 2 steps -> count 0x59, then 0x00 with tc=1 for exactly one cycle alongside tick.
- count 0x00, up=0, one step -> count 0x59, tc=1; next step -> 0x58, tc=0.
- load 0x7A (invalid) -> count 0x00; load 0x60 (>59) -> count 0x00; load and step at the same edge -> loaded value wins, tick=0.
- enable=0 for 10 clks mid-period (pcnt=2) -> count/pcnt frozen; re-enable -> next step exactly 2 clks later.
- BLANK_LZ=1, DIGITS=4, MAX_COUNT=9999, count 0x0007 -> digits 3..1 = 1111111, digit0 = 0001111. Assert reset mid-period -> count 0, tick/tc 0 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared BCD/7-segment types, the segment code table and decimal-to-BCD conversion.
package seg7_pkg;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG7_BLANK = 7'h7F;
  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // Active-low, bit order {a,b,c,d,e,f,g}; non-decimal codes show blank.
  function automatic seg7_t seg7_encode(input bcd_t d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return SEG7_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit that steps up/down when its carry/borrow input is set, with parallel load.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  bcd_t load_digit,
  input  logic step,
  input  logic up,
  input  logic carry_in,
  output bcd_t digit,
  output logic carry_out
);
  bcd_t digit_q, digit_d;
  assign carry_out = carry_in && (up ? digit_q == 4'd9 : digit_q == 4'd0);
  always_comb
    digit_d = load ? load_digit
            : !(step && carry_in) ? digit_q
            : up ? (digit_q == 4'd9 ? 4'd0 : digit_q + 4'd1)
            : (digit_q == 4'd0 ? 4'd9 : digit_q - 4'd1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) digit_q <= '0;
    else digit_q <= digit_d;
  assign digit = digit_q;
endmodule

// File: rtl/bcd_display_counter.sv
// bcd_display_counter: prescaled N-digit BCD up/down counter with load, wrap pulse and 7-segment drive.
module bcd_display_counter
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_FREQ = 1,
  parameter int DIGITS    = 4,
  parameter int MAX_COUNT = 9999,
  parameter int BLANK_LZ  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic [7*DIGITS-1:0] segs,
  output logic                tick,
  output logic                tc
);
  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PW = $clog2(DIV) + 1;
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_COUNT, DIGITS));
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic tick_q, tick_d, tc_q, tc_d;
  logic step, wrap, load_ok, digit_load, count_step, lz;
  logic [W-1:0] digit_val;
  logic [DIGITS:0] carry;
  assign step = enable && pcnt_q == PW'(DIV - 1);
  // With carry[0] tied high, the full borrow chain is set exactly when every digit is zero.
  assign wrap = up ? count == MAX_BCD : carry[DIGITS];
  always_comb begin
    load_ok = load_value <= MAX_BCD;
    for (int k = 0; k < DIGITS; k++) load_ok = load_ok && load_value[4*k+:4] <= 4'd9;
  end
  assign digit_load = load || (step && wrap);
  assign count_step = step && !load && !wrap;
  assign digit_val = load ? (load_ok ? load_value : '0) : (up ? '0 : MAX_BCD);
  assign pcnt_d = load ? '0 : !enable ? pcnt_q : step ? '0 : pcnt_q + 1'b1;
  assign tick_d = step && !load;
  assign tc_d = step && !load && wrap;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .load      (digit_load),
      .load_digit(digit_val[4*g+:4]),
      .step      (count_step),
      .up        (up),
      .carry_in  (carry[g]),
      .digit     (count[4*g+:4]),
      .carry_out (carry[g+1])
    );
  end
  always_comb begin
    lz = 1'b1;
    segs = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz = lz && count[4*k+:4] == 4'd0;
      segs[7*k+:7] = (BLANK_LZ != 0 && k > 0 && lz) ? SEG7_BLANK : seg7_encode(count[4*k+:4]);
    end
  end
  assign tick = tick_q;
  assign tc = tc_q;
endmodule

// File: tb/tb_bcd_display_counter.sv
// tb_bcd_display_counter: directed checks of prescaling, carry/borrow, wrap, load rules, hold, blanking and reset.
module tb_bcd_display_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_a, enable_a, up_a, load_a, tick_a, tc_a;
  logic [7:0] lv_a, count_a;
  logic [13:0] segs_a;
  logic reset_b, enable_b, up_b, load_b, tick_b, tc_b;
  logic [15:0] lv_b, count_b;
  logic [27:0] segs_b;
  int n_chk = 0;
  int n_fail = 0;

  bcd_display_counter #(.CLK_FREQ(8), .TICK_FREQ(2), .DIGITS(2), .MAX_COUNT(59), .BLANK_LZ(0)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .up(up_a), .load(load_a), .load_value(lv_a),
    .count(count_a), .segs(segs_a), .tick(tick_a), .tc(tc_a));
  bcd_display_counter #(.CLK_FREQ(8), .TICK_FREQ(2), .DIGITS(4), .MAX_COUNT(9999), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .up(up_b), .load(load_b), .load_value(lv_b),
    .count(count_b), .segs(segs_b), .tick(tick_b), .tc(tc_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_a_val(input logic [7:0] v);
    load_a = 1'b1;
    lv_a = v;
    cyc(1);
    load_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b0; enable_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lv_a = '0;
    reset_b = 1'b0; enable_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lv_b = '0;
    cyc(2);
    chk("rst_count", 32'(count_a), 32'h00);
    chk("rst_tick", 32'(tick_a), 32'h0);
    chk("rst_tc", 32'(tc_a), 32'h0);
    chk("rst_segs_a", 32'(segs_a), 32'({7'b0000001, 7'b0000001}));
    chk("rst_segs_b", 32'(segs_b), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0000001}));
    reset_a = 1'b1; reset_b = 1'b1; enable_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      chk($sformatf("tick_clk%0d", i), 32'(tick_a), 32'((i % 4) == 0));
    end
    chk("count_16clk", 32'(count_a), 32'h04);
    chk("segs_04", 32'(segs_a), 32'({7'b0000001, 7'b1001100}));
    load_a_val(8'h58);
    chk("load_58", 32'(count_a), 32'h58);
    chk("load_58_tick", 32'(tick_a), 32'h0);
    cyc(4);
    chk("up_59", 32'(count_a), 32'h59);
    chk("up_59_tc", 32'(tc_a), 32'h0);
    chk("segs_59", 32'(segs_a), 32'({7'b0100100, 7'b0000100}));
    cyc(4);
    chk("wrap_up_count", 32'(count_a), 32'h00);
    chk("wrap_up_tc", 32'(tc_a), 32'h1);
    chk("wrap_up_tick", 32'(tick_a), 32'h1);
    cyc(1);
    chk("wrap_up_tc_off", 32'(tc_a), 32'h0);
    up_a = 1'b0;
    load_a_val(8'h00);
    cyc(4);
    chk("wrap_dn_count", 32'(count_a), 32'h59);
    chk("wrap_dn_tc", 32'(tc_a), 32'h1);
    cyc(4);
    chk("dn_58", 32'(count_a), 32'h58);
    chk("dn_58_tc", 32'(tc_a), 32'h0);
    chk("dn_58_tick", 32'(tick_a), 32'h1);
    load_a_val(8'h7A);
    chk("load_bad_digit", 32'(count_a), 32'h00);
    load_a_val(8'h42);
    chk("load_42", 32'(count_a), 32'h42);
    load_a_val(8'h60);
    chk("load_over_max", 32'(count_a), 32'h00);
    cyc(3);
    chk("pre_collide", 32'(count_a), 32'h00);
    load_a_val(8'h25);
    chk("collide_count", 32'(count_a), 32'h25);
    chk("collide_tick", 32'(tick_a), 32'h0);
    chk("collide_tc", 32'(tc_a), 32'h0);
    cyc(2);
    enable_a = 1'b0;
    cyc(10);
    chk("hold_count", 32'(count_a), 32'h25);
    chk("hold_tick", 32'(tick_a), 32'h0);
    enable_a = 1'b1;
    cyc(1);
    chk("reen_1_tick", 32'(tick_a), 32'h0);
    chk("reen_1_count", 32'(count_a), 32'h25);
    cyc(1);
    chk("reen_2_tick", 32'(tick_a), 32'h1);
    chk("reen_2_count", 32'(count_a), 32'h24);
    up_a = 1'b1;
    cyc(4);
    chk("dir_up", 32'(count_a), 32'h25);
    load_a_val(8'h09);
    cyc(4);
    chk("carry_10", 32'(count_a), 32'h10);
    load_b = 1'b1; lv_b = 16'h0007;
    cyc(1);
    load_b = 1'b0;
    chk("b_0007", 32'(count_b), 32'h0007);
    chk("b_segs_0007", 32'(segs_b), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0001111}));
    enable_b = 1'b1;
    cyc(4);
    chk("b_segs_0008", 32'(segs_b), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0000000}));
    load_b = 1'b1; lv_b = 16'h0107;
    cyc(1);
    load_b = 1'b0;
    chk("b_segs_0107", 32'(segs_b), 32'({7'h7F, 7'b1001111, 7'b0000001, 7'b0001111}));
    load_b = 1'b1; lv_b = 16'h9999;
    cyc(1);
    load_b = 1'b0;
    chk("b_9999", 32'(count_b), 32'h9999);
    cyc(4);
    chk("b_wrap_tc", 32'(tc_b), 32'h1);
    chk("b_wrap_count", 32'(count_b), 32'h0000);
    #2 reset_b = 1'b0;
    #1;
    chk("b_rst_tc", 32'(tc_b), 32'h0);
    chk("b_rst_tick", 32'(tick_b), 32'h0);
    cyc(1);
    reset_b = 1'b1;
    load_b = 1'b1; lv_b = 16'h0042;
    cyc(1);
    load_b = 1'b0;
    cyc(2);
    #2 reset_b = 1'b0;
    #1;
    chk("b_midrst_count", 32'(count_b), 32'h0000);
    chk("b_midrst_segs", 32'(segs_b), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0000001}));
    cyc(1);
    reset_b = 1'b1;
    cyc(3);
    chk("b_midrst_no_step", 32'(tick_b), 32'h0);
    chk("b_midrst_hold", 32'(count_b), 32'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
